// File: rtl/regfile_pkg.sv
// Shared types and defaults for the shadowed register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 2;

  // Transfer controller states; values are fixed so debug dumps stay stable.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2
  } state_t;

  // Number of registers addressed by an address of the given width.
  function automatic int num_regs(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_xfer_ctrl.sv
// Save/restore sequencer: walks idx over every register once per transfer,
// blocks writes while a transfer runs and pulses done when it finishes.
module regfile_xfer_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              save_req,
  input  logic              restore_req,
  output logic              busy,
  output logic              done,
  output logic              wr_ready,
  output logic              save_en,
  output logic              restore_en,
  output logic [ADDR_W-1:0] idx,
  output state_t            state
);

  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  state_t            state_next;
  logic [ADDR_W-1:0] idx_next;
  logic              done_next;

  // State, index and done pulse registers; reset aborts any transfer silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      idx   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      done  <= done_next;
    end
  end

  // Next-state logic: save beats restore when both arrive together in IDLE.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (save_req) begin
          state_next = ST_SAVE;
          idx_next   = '0;
        end else if (restore_req) begin
          state_next = ST_RESTORE;
          idx_next   = '0;
        end
      end
      ST_SAVE, ST_RESTORE: begin
        idx_next = idx + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (idx == LAST_IDX) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  assign busy       = (state != ST_IDLE);
  assign wr_ready   = ~busy;
  assign save_en    = (state == ST_SAVE);
  assign restore_en = (state == ST_RESTORE);

endmodule

// File: rtl/regfile_shadow.sv
// Register file with two combinational read ports, one write port and a
// shadow bank copied to/from the live bank one register per cycle.
module regfile_shadow
  import regfile_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG0 = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              save_req,
  input  logic              restore_req,
  output logic              busy,
  output logic              done
);

  localparam int NUM_REGS = num_regs(ADDR_W);

  logic [DATA_W-1:0] live   [NUM_REGS];
  logic [DATA_W-1:0] shadow [NUM_REGS];

  logic              save_en;
  logic              restore_en;
  logic [ADDR_W-1:0] idx;
  state_t            dbg_state_unused;
  logic              wr_fire;

  // Handshake: a write is taken on a rising edge only when wr_en and wr_ready
  // are both high; the requester keeps wr_en and wr_addr/wr_data stable until then.
  assign wr_fire = wr_en & wr_ready;

  regfile_xfer_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_xfer (
    .clk         (clk),
    .reset       (reset),
    .save_req    (save_req),
    .restore_req (restore_req),
    .busy        (busy),
    .done        (done),
    .wr_ready    (wr_ready),
    .save_en     (save_en),
    .restore_en  (restore_en),
    .idx         (idx),
    .state       (dbg_state_unused)
  );

  // Bank updates; writes and restores never coincide because writes stall while busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        live[i]   <= '0;
        shadow[i] <= '0;
      end
    end else begin
      if (save_en) begin
        shadow[idx] <= live[idx];
      end
      if (restore_en && !((ZERO_REG0 != 0) && (idx == '0))) begin
        live[idx] <= shadow[idx];
      end
      if (wr_fire && !((ZERO_REG0 != 0) && (wr_addr == '0))) begin
        live[wr_addr] <= wr_data;
      end
    end
  end

  // Read port 1: hard zero wins over bypass, bypass wins over stored data.
  always_comb begin
    rd_data1 = live[rd_addr1];
    if ((BYPASS != 0) && wr_fire && (wr_addr == rd_addr1)) begin
      rd_data1 = wr_data;
    end
    if ((ZERO_REG0 != 0) && (rd_addr1 == '0)) begin
      rd_data1 = '0;
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rd_data2 = live[rd_addr2];
    if ((BYPASS != 0) && wr_fire && (wr_addr == rd_addr2)) begin
      rd_data2 = wr_data;
    end
    if ((ZERO_REG0 != 0) && (rd_addr2 == '0)) begin
      rd_data2 = '0;
    end
  end

endmodule

// File: tb/tb_regfile_shadow.sv
// Bench for regfile_shadow: a default instance (bypass on, no hard zero) and a
// hard-zero instance share all inputs and are checked each cycle.
module tb_regfile_shadow;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] rd_addr1, rd_addr2, wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en, save_req, restore_req;

  logic [DW-1:0] rd1_a, rd2_a, rd1_z, rd2_z;
  logic          wrr_a, busy_a, done_a, wrr_z, busy_z, done_z;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  regfile_shadow #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1), .ZERO_REG0(0)) dut_a (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1), .rd_data1(rd1_a), .rd_addr2(rd_addr2), .rd_data2(rd2_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wrr_a),
    .save_req(save_req), .restore_req(restore_req), .busy(busy_a), .done(done_a)
  );

  regfile_shadow #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1), .ZERO_REG0(1)) dut_z (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1), .rd_data1(rd1_z), .rd_addr2(rd_addr2), .rd_data2(rd2_z),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wrr_z),
    .save_req(save_req), .restore_req(restore_req), .busy(busy_z), .done(done_z)
  );

  // ---------------- reference model ----------------
  // Index 0 models dut_a, index 1 models dut_z. A transfer is tracked only as
  // "cycles remaining" and a direction.
  logic [DW-1:0] m_live   [2][NR];
  logic [DW-1:0] m_shadow [2][NR];
  int            m_left;
  bit            m_save;
  bit            m_done;

  task automatic m_reset();
    for (int m = 0; m < 2; m++)
      for (int r = 0; r < NR; r++) begin
        m_live[m][r]   = '0;
        m_shadow[m][r] = '0;
      end
    m_left = 0;
    m_save = 1'b0;
    m_done = 1'b0;
  endtask

  function automatic logic [DW-1:0] m_read(input int m, input logic [AW-1:0] a);
    if (m == 1 && a == 0) return '0;
    if (m_left == 0 && wr_en && wr_addr == a) return wr_data;
    return m_live[m][a];
  endfunction

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic m_step();
    bit nd = 1'b0;
    if (m_left > 0) begin
      int k = NR - m_left;
      for (int m = 0; m < 2; m++) begin
        if (m_save) m_shadow[m][k] = m_live[m][k];
        else if (!(m == 1 && k == 0)) m_live[m][k] = m_shadow[m][k];
      end
      m_left--;
      if (m_left == 0) nd = 1'b1;
    end else begin
      if (wr_en)
        for (int m = 0; m < 2; m++)
          if (!(m == 1 && wr_addr == 0)) m_live[m][wr_addr] = wr_data;
      if (save_req) begin
        m_save = 1'b1;
        m_left = NR;
      end else if (restore_req) begin
        m_save = 1'b0;
        m_left = NR;
      end
    end
    m_done = nd;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard check of one instance against the model for the current cycle.
  task automatic check_model(input int m, input string tag);
    logic [DW-1:0] r1, r2;
    logic          b, d, w;
    r1 = (m == 0) ? rd1_a : rd1_z;
    r2 = (m == 0) ? rd2_a : rd2_z;
    b  = (m == 0) ? busy_a : busy_z;
    d  = (m == 0) ? done_a : done_z;
    w  = (m == 0) ? wrr_a : wrr_z;
    exp_q.push_back(m_read(m, rd_addr1));
    exp_q.push_back(m_read(m, rd_addr2));
    chk({tag, "_rd1"}, {24'd0, r1}, {24'd0, exp_q.pop_front()});
    chk({tag, "_rd2"}, {24'd0, r2}, {24'd0, exp_q.pop_front()});
    chk({tag, "_busy"}, {31'd0, b}, {31'd0, (m_left > 0)});
    chk({tag, "_done"}, {31'd0, d}, {31'd0, m_done});
    chk({tag, "_wr_ready"}, {31'd0, w}, {31'd0, (m_left == 0)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic sv, input logic rs);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr1 = a1; rd_addr2 = a2;
    save_req = sv; restore_req = rs;
  endtask

  task automatic cycle_end();
    @(posedge clk);
    m_step();
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic          sv;
    logic          rs;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
    logic          eb;
    logic          ed;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic we, input int wa, input int wd, input int a1, input int a2,
                     input logic sv, input logic rs, input int e1, input int e2,
                     input logic eb, input logic ed, input int reps);
    vec_t v;
    v.we = we; v.wa = AW'(wa); v.wd = DW'(wd); v.a1 = AW'(a1); v.a2 = AW'(a2);
    v.sv = sv; v.rs = rs; v.e1 = DW'(e1); v.e2 = DW'(e2); v.eb = eb; v.ed = ed;
    for (int i = 0; i < reps; i++) vecs.push_back(v);
  endtask

  initial begin
    // write r0..r3 and read back, with same-cycle bypass on the written port
    add(1, 0, 'h04, 0, 1, 0, 0, 'h04, 'h00, 0, 0, 1);
    add(1, 1, 'h05, 0, 1, 0, 0, 'h04, 'h05, 0, 0, 1);
    add(1, 2, 'h06, 2, 3, 0, 0, 'h06, 'h00, 0, 0, 1);
    add(1, 3, 'h07, 2, 3, 0, 0, 'h06, 'h07, 0, 0, 1);
    add(0, 0, 'h00, 0, 1, 0, 0, 'h04, 'h05, 0, 0, 1);
    add(0, 0, 'h00, 2, 3, 0, 0, 'h06, 'h07, 0, 0, 1);
    // bypass of 0xA5 into r2, then stored value
    add(1, 2, 'hA5, 2, 0, 0, 0, 'hA5, 'h04, 0, 0, 1);
    add(0, 0, 'h00, 2, 3, 0, 0, 'hA5, 'h07, 0, 0, 1);
    // save: four busy cycles then done; overwrite r1 in the done cycle
    add(0, 0, 'h00, 0, 1, 1, 0, 'h04, 'h05, 0, 0, 1);
    add(0, 0, 'h00, 1, 2, 0, 0, 'h05, 'hA5, 1, 0, 4);
    add(1, 1, 'h33, 1, 3, 0, 0, 'h33, 'h07, 0, 1, 1);
    // restore: r1 returns to 5 once its slot has been copied back
    add(0, 0, 'h00, 1, 0, 0, 1, 'h33, 'h04, 0, 0, 1);
    add(0, 0, 'h00, 1, 0, 0, 0, 'h33, 'h04, 1, 0, 1);
    add(0, 0, 'h00, 1, 2, 0, 0, 'h33, 'hA5, 1, 0, 1);
    add(0, 0, 'h00, 1, 2, 0, 0, 'h05, 'hA5, 1, 0, 1);
    add(0, 0, 'h00, 1, 3, 0, 0, 'h05, 'h07, 1, 0, 1);
    add(0, 0, 'h00, 1, 3, 0, 0, 'h05, 'h07, 0, 1, 1);
    // write to r3 held during a save, accepted when busy drops
    add(0, 0, 'h00, 3, 3, 1, 0, 'h07, 'h07, 0, 0, 1);
    add(1, 3, 'h99, 3, 0, 0, 0, 'h07, 'h04, 1, 0, 4);
    add(1, 3, 'h99, 3, 0, 0, 0, 'h99, 'h04, 0, 1, 1);
    add(0, 0, 'h00, 3, 3, 0, 0, 'h99, 'h99, 0, 0, 1);
    // save and restore together: save wins, proven by a later restore
    add(0, 0, 'h00, 0, 1, 1, 1, 'h04, 'h05, 0, 0, 1);
    add(0, 0, 'h00, 0, 1, 0, 0, 'h04, 'h05, 1, 0, 4);
    add(1, 3, 'h11, 3, 0, 0, 0, 'h11, 'h04, 0, 1, 1);
    add(0, 0, 'h00, 3, 0, 0, 1, 'h11, 'h04, 0, 0, 1);
    add(0, 0, 'h00, 0, 1, 0, 0, 'h04, 'h05, 1, 0, 4);
    add(0, 0, 'h00, 3, 2, 0, 0, 'h99, 'hA5, 0, 1, 1);

    // reset state
    reset = 1'b0;
    drive(0, 0, 0, 1, 3, 0, 0);
    m_reset();
    #12;
    chk("reset_rd1", {24'd0, rd1_a}, 32'd0);
    chk("reset_rd2", {24'd0, rd2_a}, 32'd0);
    chk("reset_busy", {31'd0, busy_a}, 32'd0);
    chk("reset_done", {31'd0, done_a}, 32'd0);
    chk("reset_wr_ready", {31'd0, wrr_a}, 32'd1);
    check_model(1, "reset_z");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // directed table
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].a1, vecs[i].a2, vecs[i].sv, vecs[i].rs);
      #2;
      chk($sformatf("vec%0d_rd1", i), {24'd0, rd1_a}, {24'd0, vecs[i].e1});
      chk($sformatf("vec%0d_rd2", i), {24'd0, rd2_a}, {24'd0, vecs[i].e2});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy_a}, {31'd0, vecs[i].eb});
      chk($sformatf("vec%0d_done", i), {31'd0, done_a}, {31'd0, vecs[i].ed});
      chk($sformatf("vec%0d_wr_ready", i), {31'd0, wrr_a}, {31'd0, ~vecs[i].eb});
      check_model(1, $sformatf("vec%0d_z", i));
      cycle_end();
    end

    // hard-zero r0: write 0xFF to r0
    drive(1, 0, 'hFF, 0, 0, 0, 0);
    #2;
    chk("zero_bypass_a", {24'd0, rd1_a}, 32'hFF);
    chk("zero_bypass_z", {24'd0, rd1_z}, 32'h00);
    cycle_end();
    drive(0, 0, 0, 0, 1, 0, 0);
    #2;
    chk("zero_stored_a", {24'd0, rd1_a}, 32'hFF);
    chk("zero_stored_z", {24'd0, rd1_z}, 32'h00);
    check_model(1, "zero_z");
    cycle_end();

    // reset in the middle of a restore, with idx at 2
    drive(0, 0, 0, 1, 3, 0, 1);
    #2;
    cycle_end();
    drive(0, 0, 0, 1, 3, 0, 0);
    cycle_end();
    cycle_end();
    chk("midrst_busy_before", {31'd0, busy_a}, 32'd1);
    reset = 1'b0;
    m_reset();
    #1;
    chk("midrst_rd1", {24'd0, rd1_a}, 32'd0);
    chk("midrst_rd2", {24'd0, rd2_a}, 32'd0);
    chk("midrst_busy", {31'd0, busy_a}, 32'd0);
    chk("midrst_done", {31'd0, done_a}, 32'd0);
    check_model(1, "midrst_z");
    #2;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle_end();
      #2;
      chk($sformatf("postrst%0d_no_done", i), {31'd0, done_a}, 32'd0);
      check_model(0, "postrst_a");
      check_model(1, "postrst_z");
    end
    cycle_end();

    // randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, NR - 1)), DW'($urandom),
            AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 11) == 0));
      #2;
      check_model(0, "rand_a");
      check_model(1, "rand_z");
      cycle_end();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
